// File: rtl/timer_pkg.sv
// Shared types and helpers for the interval-timing blocks: FSM states,
// microsecond count type, held result record and clock-to-us scaling.
package timer_pkg;

    localparam int unsigned US_W = 24;

    typedef logic [US_W-1:0] us_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    typedef struct packed {
        us_t  us;
        logic valid;
    } meas_t;

    function automatic int unsigned cycles_per_us(input int unsigned clock_f);
        return clock_f / 32'd1_000_000;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus history flop; decodes rise/fall strobes from the
// last two stages once the pipeline holds only post-reset samples.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    logic       h_q,  h_d;
    logic [2:0] prime_q, prime_d;

    always_comb begin
        s1_d    = d;
        s2_d    = s1_q;
        h_d     = s2_q;
        prime_d = {prime_q[1:0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            h_q     <= 1'b0;
            prime_q <= 3'b000;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            h_q     <= h_d;
            prime_q <= prime_d;
        end
    end

    // A level already present at reset release must not look like an edge.
    assign rise = prime_q[2] &  s2_q & ~h_q;
    assign fall = prime_q[2] & ~s2_q &  h_q;

endmodule

// File: rtl/pulse_meter.sv
// Measures high-pulse width or period of an asynchronous input in whole
// microseconds, holding the result until acknowledged.
module pulse_meter
    import timer_pkg::*;
#(
    parameter int unsigned CLOCK_F     = 50_000_000,
    parameter int unsigned MAX_TIME_US = 10_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            clear,
    input  logic            mode,
    input  logic            sig_in,
    input  logic            meas_ack,
    output logic [US_W-1:0] meas_us,
    output logic            meas_valid,
    output logic            timeout,
    output logic            overrun,
    output logic            busy
);

    localparam int unsigned CPU   = cycles_per_us(CLOCK_F);
    localparam int unsigned PRE_W = $clog2(CPU);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CPU - 1);
    localparam us_t MAX_US = US_W'(MAX_TIME_US);

    logic rise;
    logic fall;

    sync_edge_det u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sig_in),
        .rise  (rise),
        .fall  (fall)
    );

    state_e           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    us_t              us_q, us_d;
    logic             mode_q, mode_d;
    meas_t            meas_q, meas_d;
    logic             timeout_q, timeout_d;
    logic             overrun_q, overrun_d;
    logic             busy_q, busy_d;

    logic end_evt;
    logic wrap;
    us_t  us_next;

    // Next-state and output decode; abort has priority over every state.
    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        us_d      = us_q;
        mode_d    = mode_q;
        meas_d    = meas_q;
        timeout_d = 1'b0;
        overrun_d = 1'b0;
        end_evt   = mode_q ? rise : fall;
        wrap      = (pre_q == PRE_MAX);
        us_next   = us_q;
        if (wrap && (us_q < MAX_US)) begin
            us_next = us_q + US_W'(1);
        end

        if (clear || !enable) begin
            state_d      = ST_IDLE;
            pre_d        = '0;
            us_d         = '0;
            meas_d.valid = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (rise) begin
                        state_d = ST_MEASURE;
                        pre_d   = '0;
                        us_d    = '0;
                        mode_d  = mode;
                    end
                end
                ST_MEASURE: begin
                    pre_d = wrap ? '0 : pre_q + PRE_W'(1);
                    us_d  = us_next;
                    // The wrap landing in the end cycle counts toward the result.
                    if (end_evt) begin
                        meas_d.us    = us_next;
                        meas_d.valid = 1'b1;
                        state_d      = ST_DONE;
                    end else if (us_next >= MAX_US) begin
                        timeout_d = 1'b1;
                        state_d   = ST_ARMED;
                    end
                end
                ST_DONE: begin
                    if (end_evt) begin
                        overrun_d = 1'b1;
                    end
                    if (meas_ack) begin
                        meas_d.valid = 1'b0;
                        state_d      = ST_ARMED;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_ARMED) || (state_d == ST_MEASURE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pre_q     <= '0;
            us_q      <= '0;
            mode_q    <= 1'b0;
            meas_q    <= '0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            us_q      <= us_d;
            mode_q    <= mode_d;
            meas_q    <= meas_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
            busy_q    <= busy_d;
        end
    end

    assign meas_us    = meas_q.us;
    assign meas_valid = meas_q.valid;
    assign timeout    = timeout_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_pulse_meter.sv
// Bench for pulse_meter: two instances (default limit and a 50 us limit) share
// directed stimulus; a cycle-count model checks every cycle, literals pin it.
module tb_pulse_meter;

    localparam int P_IDLE  = 0;
    localparam int P_ARMED = 1;
    localparam int P_MEAS  = 2;
    localparam int P_DONE  = 3;
    localparam int CPU     = 50;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic clear = 1'b0;
    logic mode = 1'b0;
    logic sig_in = 1'b0;
    logic meas_ack = 1'b0;

    logic [23:0] us0, us1;
    logic        v0, v1, to0, to1, ov0, ov1, busy0, busy1;

    int n_chk  = 0;
    int n_pass = 0;
    int to_cnt0 = 0, to_cnt1 = 0, ov_cnt0 = 0, ov_cnt1 = 0;

    always #5 clk = ~clk;

    pulse_meter #(.CLOCK_F(50_000_000), .MAX_TIME_US(10_000_000)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .mode(mode),
        .sig_in(sig_in), .meas_ack(meas_ack), .meas_us(us0), .meas_valid(v0),
        .timeout(to0), .overrun(ov0), .busy(busy0)
    );

    pulse_meter #(.CLOCK_F(50_000_000), .MAX_TIME_US(50)) dut_to (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .mode(mode),
        .sig_in(sig_in), .meas_ack(meas_ack), .meas_us(us1), .meas_valid(v1),
        .timeout(to1), .overrun(ov1), .busy(busy1)
    );

    // Model state: a measurement is "cycles since the start edge / CPU".
    int          ph[2]    = '{P_IDLE, P_IDLE};
    longint      start[2] = '{0, 0};
    logic        msel[2]  = '{1'b0, 1'b0};
    int unsigned mus[2]   = '{0, 0};
    logic        mv[2]    = '{1'b0, 1'b0};
    logic        mto[2]   = '{1'b0, 1'b0};
    logic        mov[2]   = '{1'b0, 1'b0};
    longint      cyc = 0;
    logic        p1 = 1'b0, p2 = 1'b0, p3 = 1'b0;
    int          nedge = 0;

    function automatic int unsigned max_of(input int i);
        return (i == 0) ? 10_000_000 : 50;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    task automatic step_model();
        logic r, f, e;
        longint n;
        int unsigned us;
        if (!rst_n) begin
            p1 = 1'b0; p2 = 1'b0; p3 = 1'b0; nedge = 0;
            for (int i = 0; i < 2; i++) begin
                ph[i] = P_IDLE; mus[i] = 0; mv[i] = 1'b0; mto[i] = 1'b0; mov[i] = 1'b0;
            end
            return;
        end
        r = (nedge >= 3) && p2 && !p3;
        f = (nedge >= 3) && !p2 && p3;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            mto[i] = 1'b0;
            mov[i] = 1'b0;
            if (clear || !enable) begin
                ph[i] = P_IDLE;
                mv[i] = 1'b0;
            end else begin
                case (ph[i])
                    P_IDLE: ph[i] = P_ARMED;
                    P_ARMED: if (r) begin
                        ph[i] = P_MEAS; start[i] = cyc; msel[i] = mode;
                    end
                    P_MEAS: begin
                        e  = msel[i] ? r : f;
                        n  = cyc - start[i];
                        us = int'(n / CPU);
                        if (us > max_of(i)) us = max_of(i);
                        if (e) begin
                            mus[i] = us; mv[i] = 1'b1; ph[i] = P_DONE;
                        end else if (us >= max_of(i)) begin
                            mto[i] = 1'b1; ph[i] = P_ARMED;
                        end
                    end
                    default: begin
                        e = msel[i] ? r : f;
                        if (e) mov[i] = 1'b1;
                        if (meas_ack) begin
                            mv[i] = 1'b0; ph[i] = P_ARMED;
                        end
                    end
                endcase
            end
        end
        p3 = p2; p2 = p1; p1 = sig_in;
        if (nedge < 3) nedge++;
    endtask

    // Per-cycle compare just after each rising edge.
    initial begin
        logic [27:0] a0, a1, e0, e1;
        forever begin
            @(posedge clk);
            #1;
            step_model();
            a0 = {us0, v0, to0, ov0, busy0};
            a1 = {us1, v1, to1, ov1, busy1};
            e0 = {24'(mus[0]), mv[0], mto[0], mov[0], (ph[0] == P_ARMED) || (ph[0] == P_MEAS)};
            e1 = {24'(mus[1]), mv[1], mto[1], mov[1], (ph[1] == P_ARMED) || (ph[1] == P_MEAS)};
            chk("model_cmp_dut", 64'(a0), 64'(e0));
            chk("model_cmp_dut_to", 64'(a1), 64'(e1));
            if (to0) to_cnt0++;
            if (to1) to_cnt1++;
            if (ov0) ov_cnt0++;
            if (ov1) ov_cnt1++;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_pulse();
        meas_ack = 1'b1;
        wait_cyc(1);
        meas_ack = 1'b0;
        wait_cyc(2);
    endtask

    initial begin
        wait_cyc(3);
        chk("reset_us", 64'(us0), 64'd0);
        chk("reset_valid", 64'(v0), 64'd0);
        chk("reset_busy", 64'(busy0), 64'd0);
        rst_n = 1'b1;
        enable = 1'b1;
        wait_cyc(10);
        chk("armed_busy", 64'(busy0), 64'd1);

        // 1000-cycle high pulse -> 20 us on both instances
        mode = 1'b0; sig_in = 1'b1;
        wait_cyc(1000);
        sig_in = 1'b0;
        wait_cyc(10);
        chk("width_us", 64'(us0), 64'd20);
        chk("width_valid", 64'(v0), 64'd1);
        chk("width_us_to", 64'(us1), 64'd20);
        wait_cyc(40);
        chk("width_valid_held", 64'(v0), 64'd1);
        ack_pulse();
        chk("ack_clears_valid", 64'(v0), 64'd0);
        chk("ack_rearms", 64'(busy0), 64'd1);

        // 49-cycle pulse truncates to 0 us
        sig_in = 1'b1;
        wait_cyc(49);
        sig_in = 1'b0;
        wait_cyc(10);
        chk("trunc_us", 64'(us0), 64'd0);
        chk("trunc_valid", 64'(v0), 64'd1);
        ack_pulse();

        // Period mode, rises 5000 cycles apart, third rise overruns
        mode = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sig_in = 1'b1;
            wait_cyc(100);
            sig_in = 1'b0;
            wait_cyc(4900);
        end
        wait_cyc(10);
        chk("period_us", 64'(us0), 64'd100);
        chk("period_valid", 64'(v0), 64'd1);
        chk("overrun_count", 64'(ov_cnt0), 64'd1);
        chk("period_timeouts_to", 64'(to_cnt1), 64'd3);
        chk("period_to_valid", 64'(v1), 64'd0);
        ack_pulse();

        // 3000-cycle pulse: 60 us normally, timeout at 50 us on dut_to
        mode = 1'b0; sig_in = 1'b1;
        wait_cyc(3000);
        sig_in = 1'b0;
        wait_cyc(10);
        chk("long_us", 64'(us0), 64'd60);
        chk("timeout_count_to", 64'(to_cnt1), 64'd4);
        chk("timeout_valid_to", 64'(v1), 64'd0);
        chk("timeout_us_kept", 64'(us1), 64'd0);
        chk("timeout_rearm_to", 64'(busy1), 64'd1);
        ack_pulse();

        // Clear 10 us into a measurement
        sig_in = 1'b1;
        wait_cyc(503);
        clear = 1'b1;
        wait_cyc(1);
        clear = 1'b0;
        wait_cyc(100);
        sig_in = 1'b0;
        wait_cyc(10);
        chk("clear_valid", 64'(v0), 64'd0);
        chk("clear_us_kept", 64'(us0), 64'd60);
        chk("clear_no_timeout", 64'(to_cnt0), 64'd0);

        // Reset mid-measurement, released with sig_in still high
        sig_in = 1'b1;
        wait_cyc(300);
        rst_n = 1'b0;
        wait_cyc(1);
        chk("rst_us", 64'(us0), 64'd0);
        chk("rst_busy", 64'(busy0), 64'd0);
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(200);
        sig_in = 1'b0;
        wait_cyc(10);
        chk("rst_no_spurious", 64'(v0), 64'd0);
        chk("rst_no_spurious_to", 64'(v1), 64'd0);
        chk("rst_no_pulses", 64'(ov_cnt0 + to_cnt0), 64'd1);

        // Normal operation after reset: 500 cycles -> 10 us
        sig_in = 1'b1;
        wait_cyc(500);
        sig_in = 1'b0;
        wait_cyc(10);
        chk("post_rst_us", 64'(us0), 64'd10);
        chk("post_rst_us_to", 64'(us1), 64'd10);
        chk("post_rst_valid", 64'(v1), 64'd1);
        chk("final_timeout_count_to", 64'(to_cnt1), 64'd4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
